// File: rtl/alu_iter_if.sv
// rtl/alu_iter_if.sv - operand/strobe/result bundle between the controller and alu_iter
interface alu_iter_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int FUN_WIDTH     = 4,
    parameter int ALU_OUT_WIDTH = 2 * DATA_WIDTH
);
    logic [DATA_WIDTH-1:0]    A;
    logic [DATA_WIDTH-1:0]    B;
    logic                     ALU_EN;
    logic [FUN_WIDTH-1:0]     ALU_FUN;
    logic [ALU_OUT_WIDTH-1:0] ALU_OUT;
    logic                     ALU_OUT_VALID;
    logic                     ALU_BUSY;

    modport master (
        output A, B, ALU_EN, ALU_FUN,
        input  ALU_OUT, ALU_OUT_VALID, ALU_BUSY
    );

    modport slave (
        input  A, B, ALU_EN, ALU_FUN,
        output ALU_OUT, ALU_OUT_VALID, ALU_BUSY
    );
endinterface

// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - registered ALU, restoring iterative divide when ALU_ITER_DIV_EN is defined
module alu_iter #(
    parameter int DATA_WIDTH    = 8,
    parameter int FUN_WIDTH     = 4,
    parameter int ALU_OUT_WIDTH = 2 * DATA_WIDTH
) (
    input  logic      CLK,
    input  logic      RST,
    alu_iter_if.slave bus
);
    localparam logic [FUN_WIDTH-1:0] FUN_DIV = FUN_WIDTH'(3);

    logic [ALU_OUT_WIDTH-1:0] a_ext;
    logic [ALU_OUT_WIDTH-1:0] b_ext;
    logic [ALU_OUT_WIDTH-1:0] op_result;
    logic [ALU_OUT_WIDTH-1:0] out_q;
    logic [ALU_OUT_WIDTH-1:0] out_next;
    logic                     valid_q;
    logic                     valid_next;

    assign a_ext = ALU_OUT_WIDTH'(bus.A);
    assign b_ext = ALU_OUT_WIDTH'(bus.B);

    always_comb begin
        op_result = '0;
        case (bus.ALU_FUN)
            4'h0: op_result = a_ext + b_ext;
            4'h1: op_result = a_ext - b_ext;
            4'h2: op_result = a_ext * b_ext;
            4'h3: begin
                if (bus.B == '0) op_result = {bus.A, {DATA_WIDTH{1'b1}}};
`ifndef ALU_ITER_DIV_EN
                else op_result = {bus.A % bus.B, bus.A / bus.B};
`endif
            end
            4'h4: op_result = a_ext & b_ext;
            4'h5: op_result = a_ext | b_ext;
            4'h6: op_result = {{DATA_WIDTH{1'b0}}, ~(bus.A & bus.B)};
            4'h7: op_result = {{DATA_WIDTH{1'b0}}, ~(bus.A | bus.B)};
            4'h8: op_result = a_ext ^ b_ext;
            4'h9: op_result = {{DATA_WIDTH{1'b0}}, ~(bus.A ^ bus.B)};
            4'hA: op_result = (bus.A == bus.B) ? ALU_OUT_WIDTH'(1) : '0;
            4'hB: op_result = (bus.A >  bus.B) ? ALU_OUT_WIDTH'(2) : '0;
            4'hC: op_result = (bus.A <  bus.B) ? ALU_OUT_WIDTH'(3) : '0;
            4'hD: op_result = a_ext >> 1;
            4'hE: op_result = a_ext << 1;
            default: op_result = '0;
        endcase
    end

`ifdef ALU_ITER_DIV_EN
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        DIV  = 1'b1
    } state_t;

    state_t              state, state_next;
    logic [CW-1:0]       count, count_next;
    logic [DATA_WIDTH-1:0] dvd, dvd_next;
    logic [DATA_WIDTH-1:0] dvs, dvs_next;
    logic [DATA_WIDTH-1:0] rem, rem_next;
    logic [DATA_WIDTH-1:0] quo, quo_next;
    logic [DATA_WIDTH:0]   rem_shift;
    logic [DATA_WIDTH:0]   rem_diff;
    logic                  take_bit;

    // One restoring step: bring in the next dividend MSB, subtract if it fits
    assign rem_shift = {rem, dvd[DATA_WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, dvs};
    assign take_bit  = (rem_shift >= {1'b0, dvs});

    always_comb begin
        state_next = state;
        count_next = count;
        dvd_next   = dvd;
        dvs_next   = dvs;
        rem_next   = rem;
        quo_next   = quo;
        out_next   = out_q;
        valid_next = 1'b0;
        case (state)
            IDLE: begin
                if (bus.ALU_EN) begin
                    if (bus.ALU_FUN == FUN_DIV && bus.B != '0) begin
                        dvd_next   = bus.A;
                        dvs_next   = bus.B;
                        rem_next   = '0;
                        quo_next   = '0;
                        count_next = CW'(DATA_WIDTH);
                        state_next = DIV;
                    end else begin
                        out_next   = op_result;
                        valid_next = 1'b1;
                    end
                end
            end
            DIV: begin
                rem_next   = take_bit ? rem_diff[DATA_WIDTH-1:0] : rem_shift[DATA_WIDTH-1:0];
                quo_next   = {quo[DATA_WIDTH-2:0], take_bit};
                dvd_next   = dvd << 1;
                count_next = count - 1'b1;
                if (count == CW'(1)) begin
                    out_next   = {rem_next, quo_next};
                    valid_next = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state   <= IDLE;
            count   <= '0;
            dvd     <= '0;
            dvs     <= '0;
            rem     <= '0;
            quo     <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_next;
            count   <= count_next;
            dvd     <= dvd_next;
            dvs     <= dvs_next;
            rem     <= rem_next;
            quo     <= quo_next;
            out_q   <= out_next;
            valid_q <= valid_next;
        end
    end

    assign bus.ALU_BUSY = (state == DIV);
`else
    always_comb begin
        out_next   = out_q;
        valid_next = 1'b0;
        if (bus.ALU_EN) begin
            out_next   = op_result;
            valid_next = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_next;
            valid_q <= valid_next;
        end
    end

    assign bus.ALU_BUSY = 1'b0;
`endif

    assign bus.ALU_OUT       = out_q;
    assign bus.ALU_OUT_VALID = valid_q;
endmodule

// File: tb/tb_alu_iter.sv
// tb/tb_alu_iter.sv - directed-vector bench for alu_iter (both ALU_ITER_DIV_EN builds)
module tb_alu_iter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_iter_if #(.DATA_WIDTH(8), .FUN_WIDTH(4), .ALU_OUT_WIDTH(16)) bus ();

    alu_iter #(.DATA_WIDTH(8), .FUN_WIDTH(4), .ALU_OUT_WIDTH(16)) u_dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge; drive and sample here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] fun, input logic [7:0] a, input logic [7:0] b);
        bus.ALU_FUN = fun;
        bus.A       = a;
        bus.B       = b;
        bus.ALU_EN  = 1'b1;
    endtask

    task automatic single(input string tag, input logic [3:0] fun, input logic [7:0] a,
                          input logic [7:0] b, input logic [15:0] expected);
        issue(fun, a, b);
        tick();
        bus.ALU_EN = 1'b0;
        check({tag, "_valid"}, 32'(bus.ALU_OUT_VALID), 32'd1);
        check({tag, "_out"}, 32'(bus.ALU_OUT), 32'(expected));
        check({tag, "_busy"}, 32'(bus.ALU_BUSY), 32'd0);
    endtask

    initial begin
        int busy_cycles;
        int valid_seen;

        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        bus.A      = '0;
        bus.B      = '0;
        bus.ALU_EN = 1'b0;
        bus.ALU_FUN = '0;
        tick();
        tick();
        check("rst_out", 32'(bus.ALU_OUT), 32'h0);
        check("rst_valid", 32'(bus.ALU_OUT_VALID), 32'd0);
        check("rst_busy", 32'(bus.ALU_BUSY), 32'd0);
        rst_n = 1'b1;
        tick();

        // ADD, then confirm the pulse is a single cycle and the result holds
        single("add", 4'h0, 8'hC8, 8'h64, 16'h012C);
        tick();
        check("add_pulse_width", 32'(bus.ALU_OUT_VALID), 32'd0);
        check("add_hold", 32'(bus.ALU_OUT), 32'h012C);

        // Back-to-back MUL then SUB: valid in consecutive cycles
        single("mul", 4'h2, 8'hFF, 8'hFF, 16'hFE01);
        single("sub", 4'h1, 8'h03, 8'h05, 16'hFFFE);
        tick();
        check("sub_pulse_width", 32'(bus.ALU_OUT_VALID), 32'd0);

        single("div0", 4'h3, 8'h2A, 8'h00, 16'h2AFF);
        tick();
        check("div0_busy_after", 32'(bus.ALU_BUSY), 32'd0);

        single("eq", 4'hA, 8'h10, 8'h10, 16'h0001);
        single("gt", 4'hB, 8'h10, 8'h10, 16'h0000);
        single("lt", 4'hC, 8'h10, 8'h10, 16'h0000);
        single("gt_true", 4'hB, 8'h11, 8'h10, 16'h0002);
        single("lt_true", 4'hC, 8'h0F, 8'h10, 16'h0003);
        single("shr", 4'hD, 8'h81, 8'h00, 16'h0040);
        single("shl", 4'hE, 8'h81, 8'h00, 16'h0102);
        single("nand", 4'h6, 8'hF0, 8'h3C, 16'h00CF);
        single("nor", 4'h7, 8'hF0, 8'h3C, 16'h0003);
        single("xor", 4'h8, 8'hF0, 8'h3C, 16'h00CC);
        single("xnor", 4'h9, 8'hF0, 8'h3C, 16'h0033);
        single("or", 4'h5, 8'hF0, 8'h3C, 16'h00FC);
        single("zero_fun", 4'hF, 8'hAA, 8'h55, 16'h0000);
        tick();

        // 200 = 7*28 + 4 -> {rem 8'h04, quo 8'h1C}
`ifdef ALU_ITER_DIV_EN
        issue(4'h3, 8'd200, 8'd7);
        busy_cycles = 0;
        valid_seen  = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            bus.ALU_EN = 1'b0;
            if (c == 1) begin
                bus.A = 8'h00;
                bus.B = 8'h01;
            end
            if (c == 3) issue(4'h0, 8'h01, 8'h01);
            if (bus.ALU_BUSY === 1'b1) busy_cycles++;
            if (bus.ALU_OUT_VALID === 1'b1) valid_seen++;
        end
        check("div_busy_cycles", 32'(busy_cycles), 32'd8);
        check("div_no_early_valid", 32'(valid_seen), 32'd0);
        tick();
        check("div_valid", 32'(bus.ALU_OUT_VALID), 32'd1);
        check("div_out", 32'(bus.ALU_OUT), 32'h041C);
        check("div_busy_done", 32'(bus.ALU_BUSY), 32'd0);
        tick();
        check("div_ignored_en", 32'(bus.ALU_OUT_VALID), 32'd0);
        check("div_hold", 32'(bus.ALU_OUT), 32'h041C);

        // Reset during cycle 5 of a divide aborts it
        issue(4'h3, 8'd100, 8'd3);
        for (int c = 1; c <= 5; c++) begin
            tick();
            bus.ALU_EN = 1'b0;
        end
        rst_n = 1'b0;
        tick();
        check("abort_out", 32'(bus.ALU_OUT), 32'h0);
        check("abort_valid", 32'(bus.ALU_OUT_VALID), 32'd0);
        check("abort_busy", 32'(bus.ALU_BUSY), 32'd0);
        rst_n = 1'b1;
        valid_seen = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.ALU_OUT_VALID === 1'b1) valid_seen++;
        end
        check("abort_no_valid", 32'(valid_seen), 32'd0);
`else
        single("div", 4'h3, 8'd200, 8'd7, 16'h041C);
        single("div_b2b", 4'h3, 8'd100, 8'd3, 16'h0121);
        tick();
        check("div_busy_idle", 32'(bus.ALU_BUSY), 32'd0);
`endif
        single("and", 4'h4, 8'hF0, 8'h3C, 16'h0030);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
